sel138_rr_arbiter: RTL
======================

// Module: sel138_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 74LS138-style 3-to-8 select decoder between 8 requesters.
//  Drives the decoder's G1/G2A/G2B enables and C/B/A address, so at most one active-low Y line is
//  asserted per grant. Enforces a bounded hold time and break-before-make dead cycles between grants.
//  Sits between the requesting blocks (bus masters, scan/chip-select users) and the decoder instance.
// PARAMETERS
//  HOLD_MAX    15  maximum consecutive grant cycles per winner (1..255)
//  GAP_CYCLES  1   dead cycles with decoder disabled between grants (1..15; 0 not allowed)
// PORTS
//  clk        in   1  single system clock, all logic on rising edge
//  rst        in   1  reset; one clock, reset is synchronous and active-high
//  REQ        in   8  REQ[i]=1: requester i wants the decoder; hold high for the whole grant
//  G1         out  1  decoder enable, active high
//  G2A        out  1  decoder enable, active low (always equal to G2B)
//  G2B        out  1  decoder enable, active low
//  C,B,A      out  1  each; decoder address {C,B,A} = granted index
//  GNT_VALID  out  1  1 while a grant is active (== G1)
//  GNT_ID     out  3  granted index; equals {C,B,A}
// BEHAVIOUR
//  - All outputs registered. Reset (sampled at the edge): state=IDLE, G1=0, G2A=G2B=1, {C,B,A}=000,
//    GNT_VALID=0, GNT_ID=0, last_id=7 (so index 0 has top priority), hold/gap counters=0.
//  - Decoder enabled iff state==GRANT: G1=1, G2A=G2B=0. Otherwise G1=0, G2A=G2B=1.
//  - States: IDLE, GRANT, GAP.
//  - IDLE: if REQ!=0, pick the first set bit scanning last_id+1, +2, ... mod 8 (wraps 7->0).
//    Next cycle: GRANT, {C,B,A}=GNT_ID=pick, hold_cnt=1, last_id=pick. Latency REQ->G1 = 1 clock.
//    If REQ==0, remain in IDLE.
//  - GRANT: each edge, if REQ[GNT_ID]==0 or hold_cnt==HOLD_MAX -> GAP, gap_cnt=1;
//    else hold_cnt++. Grant therefore lasts 1..HOLD_MAX cycles. Other REQ bits ignored.
//  - GAP: enables off; {C,B,A}/GNT_ID hold last value (no address glitch while disabled).
//    While gap_cnt<GAP_CYCLES: gap_cnt++. When gap_cnt==GAP_CYCLES, arbitrate exactly as IDLE:
//    REQ!=0 -> GRANT next cycle, else -> IDLE.
//  - Hold-limit expiry with REQ still high: requester loses; round robin moves past it; if it is
//    the only requester it is re-granted after the gap.
//  - REQ rising and falling in the same window never produces a grant shorter than 1 cycle.
//  - rst mid-grant or mid-gap: next edge forces reset values; no partial grant survives.
//  - hold_cnt width = 8 bits; gap_cnt width = 4 bits; no overflow within parameter ranges.
// STRUCTURE
//  - sel138_pkg (shared include): state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2;
//    ENABLE/DISABLE values of {G1,G2A,G2B} = 3'b100 / 3'b011.
//  - Sub-module rr_pick8: combinational rotating priority picker (REQ[7:0], last_id[2:0] ->
//    any, pick[2:0]). Top level: FSM, counters, output registers.
// TESTING (HOLD_MAX=4, GAP_CYCLES=1, outputs fed into a gate74LS138D model)
//  1 rst=1 for 2 clocks, REQ=FF -> G1=0, G2A=G2B=1, GNT_VALID=0, CBA=000, decoder Y=FF.
//  2 REQ=01 at edge 0 -> edge1 G1=1, CBA=000, Y=FE; REQ=00 at edge 3 -> edge 4 G1=0, Y=FF.
//  3 REQ=81 constant -> grant 0 for 4 cycles, 1 gap, grant 7 for 4, 1 gap, grant 0 again.
//  4 Wrap: after grant to 6, REQ=41 -> next grant 0 (scan 7, 0), then 6.
//  5 REQ=FF constant -> grant order 0,1,...,7,0; every grant 4 cycles, gaps of exactly 1 cycle.
//  6 rst=1 during cycle 2 of grant to 5 -> next edge G1=0, CBA=000; after release with REQ=24
//    -> grant to 2 first (last_id reset to 7).

Source files
------------

// File: rtl/sel138_rr_arbiter_pkg.sv
// Shared encodings for the 74LS138 round-robin arbiter: FSM states and decoder enable patterns.
package sel138_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // {G1,G2A,G2B}: only the enabled pattern lets a Y line go low
    localparam logic [2:0] DEC_ENABLE  = 3'b100;
    localparam logic [2:0] DEC_DISABLE = 3'b011;

    localparam logic [2:0] LAST_ID_RESET = 3'd7;

endpackage

// File: rtl/sel138_rr_arbiter_if.sv
// Requester/decoder-side bundle: REQ in, decoder enables/address and grant status out.
interface sel138_rr_arbiter_if;

    logic [7:0] REQ;
    logic       G1;
    logic       G2A;
    logic       G2B;
    logic       C;
    logic       B;
    logic       A;
    logic       GNT_VALID;
    logic [2:0] GNT_ID;

    modport master (
        output REQ,
        input  G1, G2A, G2B, C, B, A, GNT_VALID, GNT_ID
    );

    modport slave (
        input  REQ,
        output G1, G2A, G2B, C, B, A, GNT_VALID, GNT_ID
    );

endinterface

// File: rtl/sel138_rr_arbiter_rr_pick8.sv
// Rotating-priority picker: first set request bit scanning lastId+1, lastId+2, ... modulo 8.
module rr_pick8 (
    input  logic [7:0] req_i,
    input  logic [2:0] lastId_i,
    output logic       any_o,
    output logic [2:0] pick_o
);

    logic [2:0] idx;

    // Scan from farthest to nearest so the nearest set bit after lastId wins
    always_comb begin
        any_o  = 1'b0;
        pick_o = lastId_i;
        idx    = lastId_i;
        for (int off = 8; off >= 1; off--) begin
            idx = lastId_i + 3'(off);
            if (req_i[idx]) begin
                any_o  = 1'b1;
                pick_o = idx;
            end
        end
    end

endmodule

// File: rtl/sel138_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among 8 requesters, with bounded hold
// time and break-before-make dead cycles; every decoder-facing output comes from a flop.
module sel138_rr_arbiter
    import sel138_rr_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX   = 15,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sel138_rr_arbiter_if.slave   bus
);

    localparam logic [7:0] HOLD_MAX_C   = 8'(HOLD_MAX);
    localparam logic [3:0] GAP_CYCLES_C = 4'(GAP_CYCLES);

    state_e     state_q,   state_d;
    logic [7:0] holdCnt_q, holdCnt_d;
    logic [3:0] gapCnt_q,  gapCnt_d;
    logic [2:0] lastId_q,  lastId_d;
    logic [2:0] gntId_q,   gntId_d;
    logic [2:0] dec_q,     dec_d;

    logic       pickAny;
    logic [2:0] pickId;
    logic       arbNow;

    rr_pick8 u_pick (
        .req_i    (bus.REQ),
        .lastId_i (lastId_q),
        .any_o    (pickAny),
        .pick_o   (pickId)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            holdCnt_q <= 8'd0;
            gapCnt_q  <= 4'd0;
            lastId_q  <= LAST_ID_RESET;
            gntId_q   <= 3'd0;
            dec_q     <= DEC_DISABLE;
        end else begin
            state_q   <= state_d;
            holdCnt_q <= holdCnt_d;
            gapCnt_q  <= gapCnt_d;
            lastId_q  <= lastId_d;
            gntId_q   <= gntId_d;
            dec_q     <= dec_d;
        end
    end

    // The address is left untouched outside a new grant so it never moves while disabled
    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        gapCnt_d  = gapCnt_q;
        lastId_d  = lastId_q;
        gntId_d   = gntId_q;
        dec_d     = dec_q;
        arbNow    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arbNow = 1'b1;
            end
            ST_GRANT: begin
                if (!bus.REQ[gntId_q] || (holdCnt_q == HOLD_MAX_C)) begin
                    state_d  = ST_GAP;
                    gapCnt_d = 4'd1;
                    dec_d    = DEC_DISABLE;
                end else begin
                    holdCnt_d = holdCnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (gapCnt_q < GAP_CYCLES_C) begin
                    gapCnt_d = gapCnt_q + 4'd1;
                end else begin
                    arbNow = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dec_d   = DEC_DISABLE;
            end
        endcase

        if (arbNow) begin
            if (pickAny) begin
                state_d   = ST_GRANT;
                gntId_d   = pickId;
                lastId_d  = pickId;
                holdCnt_d = 8'd1;
                dec_d     = DEC_ENABLE;
            end else begin
                state_d   = ST_IDLE;
                dec_d     = DEC_DISABLE;
            end
        end
    end

    assign bus.G1        = dec_q[2];
    assign bus.G2A       = dec_q[1];
    assign bus.G2B       = dec_q[0];
    assign bus.C         = gntId_q[2];
    assign bus.B         = gntId_q[1];
    assign bus.A         = gntId_q[0];
    assign bus.GNT_VALID = dec_q[2];
    assign bus.GNT_ID    = gntId_q;

endmodule
